dbus_axil_bridge: RTL
=====================

DBUS_AXIL_BRIDGE -- requirements
Module: dbus_axil_bridge

Interface
REQ-001 Parameter XLEN, 64, data and address width in bits.
REQ-002 Parameter XBYTES, XLEN/8, number of write-strobe bits.
REQ-003 clk_i  in  1  sole clock; all state updates on posedge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 req_wvalid_i  in  1  store request from the LSU stage.
REQ-006 req_arvalid_i  in  1  load request from the LSU stage.
REQ-007 req_addr_i  in  XLEN  byte address.
REQ-008 req_wdata_i  in  XLEN  lane-replicated store data.
REQ-009 req_wstrb_i  in  XBYTES  store byte enables.
REQ-010 rdata_o  out  XLEN  registered full-width load data returned to the LSU.
REQ-011 stall_o  out  1  pipeline hold; the LSU keeps all req_* stable while it is high.
REQ-012 err_o  out  1  one-cycle pulse on a non-OKAY response.
REQ-013 m_awvalid_o/m_awready_i, m_awaddr_o[XLEN]: AXI4-Lite write-address channel.
REQ-014 m_wvalid_o/m_wready_i, m_wdata_o[XLEN], m_wstrb_o[XBYTES]: write-data channel.
REQ-015 m_bvalid_i/m_bready_o, m_bresp_i[2]: write-response channel.
REQ-016 m_arvalid_o/m_arready_i, m_araddr_o[XLEN]: read-address channel.
REQ-017 m_rvalid_i/m_rready_o, m_rdata_i[XLEN], m_rresp_i[2]: read-data channel.

Function
REQ-018 The FSM SHALL have states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and DONE.
REQ-019 In IDLE with req_wvalid_i=1, the block SHALL capture addr, wdata and wstrb into registers and go to WR_REQ.
REQ-020 In IDLE with only req_arvalid_i=1, the block SHALL capture addr and go to RD_REQ.
REQ-021 If wvalid and arvalid are both 1, the store SHALL win and the load SHALL be ignored.
REQ-022 stall_o SHALL equal (IDLE and any request valid) or state in {WR_REQ, WR_RESP, RD_REQ, RD_RESP}; it SHALL be 0 in DONE and in idle IDLE.
REQ-023 In WR_REQ, m_awvalid_o and m_wvalid_o SHALL be driven from registers, each deasserting independently after its own handshake (aw_done and w_done flags).
REQ-024 WR_REQ SHALL advance to WR_RESP in the cycle both handshakes are complete, including the case where both complete in the same cycle.
REQ-025 In WR_RESP, m_bready_o SHALL be 1; on m_bvalid_i the block SHALL go to DONE.
REQ-026 In RD_REQ, m_arvalid_o SHALL be 1 until m_arready_i; the block SHALL then go to RD_RESP.
REQ-027 In RD_RESP, m_rready_o SHALL be 1; on m_rvalid_i, rdata_o SHALL load m_rdata_i and the block SHALL go to DONE.
REQ-028 rdata_o SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-029 err_o SHALL be 1 during DONE if and only if the captured bresp or rresp is nonzero.
REQ-030 DONE SHALL last exactly one cycle, return to IDLE, and ignore req_* (no re-acceptance of the held request).
REQ-031 Once raised, a valid SHALL NOT drop before its ready; m_*addr_o, m_wdata_o and m_wstrb_o SHALL remain stable while their valid is high.
REQ-032 Minimum latency, from acceptance to DONE with zero-wait slaves, SHALL be 3 cycles; the LSU samples rdata_o in the cycle after DONE.

Reset
REQ-033 With rst_ni=0, the block SHALL immediately enter IDLE, drive all m_*valid_o and m_*ready_o to 0, and clear stall_o, err_o, rdata_o, the aw_done/w_done flags and the captured request registers to 0.
REQ-034 A reset mid-transaction SHALL abandon the transaction with no DONE and no err_o pulse.

Verification
REQ-035 Load at 0x1000 with rdata 0xDEADBEEF_01234567 and zero-wait slave -> stall_o high for 3 cycles, one DONE cycle, then rdata_o=0xDEADBEEF_01234567, err_o=0.
REQ-036 Store addr 0x2004, wstrb 0xF0, awready 2 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid held stable for 3 cycles, a single B handshake, then DONE.
REQ-037 Store with m_bresp_i=2'b10 -> err_o=1 for exactly one cycle, in DONE.
REQ-038 wvalid and arvalid both 1 -> only AW/W issued, no AR, rdata_o unchanged.
REQ-039 rst_ni asserted while in RD_RESP -> all outputs 0 immediately; a subsequent load completes normally.
REQ-040 Back-to-back loads, request held through DONE -> exactly one AR per request, with an IDLE cycle between requests.

Source files
------------

// File: rtl/dbus_axil_bridge.sv
// LSU data-bus to AXI4-Lite bridge: one load or store in flight, 3 cycles from acceptance to DONE at best.
// The LSU is stalled from acceptance through the response; every master valid is held until its ready.
module dbus_axil_bridge #(
  parameter int XLEN   = 64,
  parameter int XBYTES = XLEN/8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_wvalid_i,
  input  logic              req_arvalid_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [XBYTES-1:0] req_wstrb_i,
  output logic [XLEN-1:0]   rdata_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [XLEN-1:0]   m_awaddr_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  output logic [XLEN-1:0]   m_wdata_o,
  output logic [XBYTES-1:0] m_wstrb_o,
  input  logic              m_bvalid_i,
  output logic              m_bready_o,
  input  logic [1:0]        m_bresp_i,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  output logic [XLEN-1:0]   m_araddr_o,
  input  logic              m_rvalid_i,
  output logic              m_rready_o,
  input  logic [XLEN-1:0]   m_rdata_i,
  input  logic [1:0]        m_rresp_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XBYTES-1:0] wstrb;
  } req_t;

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic            aw_vld_q, aw_vld_d;
  logic            w_vld_q, w_vld_d;
  logic            ar_vld_q, ar_vld_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic aw_hs, w_hs, ar_hs;
  logic aw_ok, w_ok;
  logic req_any;

  assign aw_hs   = aw_vld_q & m_awready_i;
  assign w_hs    = w_vld_q & m_wready_i;
  assign ar_hs   = ar_vld_q & m_arready_i;
  // A channel counts as finished if it completed earlier or completes this cycle.
  assign aw_ok   = aw_done_q | aw_hs;
  assign w_ok    = w_done_q | w_hs;
  assign req_any = req_wvalid_i | req_arvalid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_wvalid_i) begin
          state_d = WR_REQ;
        end else if (req_arvalid_i) begin
          state_d = RD_REQ;
        end
      end
      WR_REQ:  if (aw_ok && w_ok) state_d = WR_RESP;
      WR_RESP: if (m_bvalid_i) state_d = DONE;
      RD_REQ:  if (ar_hs) state_d = RD_RESP;
      RD_RESP: if (m_rvalid_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d     = req_q;
    aw_vld_d  = aw_vld_q;
    w_vld_d   = w_vld_q;
    ar_vld_d  = ar_vld_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        // Store has priority; a simultaneous load is simply not accepted.
        if (req_wvalid_i) begin
          req_d.addr  = req_addr_i;
          req_d.wdata = req_wdata_i;
          req_d.wstrb = req_wstrb_i;
          aw_vld_d    = 1'b1;
          w_vld_d     = 1'b1;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          err_d       = 1'b0;
        end else if (req_arvalid_i) begin
          req_d.addr  = req_addr_i;
          req_d.wdata = '0;
          req_d.wstrb = '0;
          ar_vld_d    = 1'b1;
          err_d       = 1'b0;
        end
      end
      WR_REQ: begin
        if (aw_hs) begin
          aw_vld_d  = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          w_vld_d  = 1'b0;
          w_done_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_bvalid_i) err_d = |m_bresp_i;
      end
      RD_REQ: begin
        if (ar_hs) ar_vld_d = 1'b0;
      end
      RD_RESP: begin
        if (m_rvalid_i) begin
          rdata_d = m_rdata_i;
          err_d   = |m_rresp_i;
        end
      end
      DONE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      default: begin
        aw_vld_d = 1'b0;
        w_vld_d  = 1'b0;
        ar_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q     <= '0;
      aw_vld_q  <= 1'b0;
      w_vld_q   <= 1'b0;
      ar_vld_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      req_q     <= req_d;
      aw_vld_q  <= aw_vld_d;
      w_vld_q   <= w_vld_d;
      ar_vld_q  <= ar_vld_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    // Gate the IDLE stall term with reset so a held request cannot stall the LSU while in reset.
    stall_o     = rst_ni & (((state_q == IDLE) & req_any) |
                            (state_q == WR_REQ) | (state_q == WR_RESP) |
                            (state_q == RD_REQ) | (state_q == RD_RESP));
    err_o       = (state_q == DONE) & err_q;
    m_awvalid_o = aw_vld_q;
    m_wvalid_o  = w_vld_q;
    m_arvalid_o = ar_vld_q;
    m_bready_o  = (state_q == WR_RESP);
    m_rready_o  = (state_q == RD_RESP);
    m_awaddr_o  = req_q.addr;
    m_araddr_o  = req_q.addr;
    m_wdata_o   = req_q.wdata;
    m_wstrb_o   = req_q.wstrb;
    rdata_o     = rdata_q;
  end

endmodule
